instr_mem_responder: RTL and testbench

Responder side of the instruction-fetch memory interface. Accepts word-aligned fetch addresses from the fetch stage over a valid/ready request channel. Performs a fixed-latency lookup in an internal instruction store and returns instructions in order over a valid/ready response channel. Provides a flush input so branch redirects can discard stale fetches, and a load port so benches and boot logic can write the store.

---
 rtl/instr_mem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_instr_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: responder side of the instruction-fetch memory port.
// Accepts word-aligned fetch addresses, looks them up in an internal store
// with a fixed latency and returns the instructions in order through a small
// credit-protected response FIFO. Flush drops everything in flight; a
// separate load port writes the store.
module instr_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,            // legal range 1..4
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [63:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned FIFO_DEPTH = LATENCY + 1;
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

    // One lookup result as it travels through the pipeline and the FIFO.
    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } rsp_entry_t;

    // ------------------------------------------------------------------
    // Instruction store and load port
    // ------------------------------------------------------------------
    logic [31:0]   store_q [DEPTH_WORDS];
    logic          store_we;
    logic [AW-1:0] store_widx;

    // Qualify a load: aligned, in range (upper bits included), not in reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        store_we   = 1'b0;
        store_widx = ld_addr[AW+1:2];
        if (ld_en && !reset && (ld_addr[1:0] == 2'b00) &&
            (ld_addr[63:2] < 62'(DEPTH_WORDS))) begin
            store_we = 1'b1;
        end
    end

    // Store write; contents survive reset so boot-loaded code stays valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of every other flop.
        if (store_we) begin
            store_q[store_widx] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Request side: lookup and credit
    // ------------------------------------------------------------------
    rsp_entry_t    lookup;
    logic          accept;
    logic          pop;
    logic [CW-1:0] outstanding_q, outstanding_d;

    // Read the store in the acceptance cycle; a same-cycle load lands at the
    // edge, so this read sees the old word.
    always_comb begin
        lookup = '0;
        if ((req_addr[1:0] != 2'b00) || (req_addr[63:2] >= 62'(DEPTH_WORDS))) begin
            lookup.err   = 1'b1;
            lookup.instr = NOP_WORD;
        end else begin
            lookup.instr = store_q[req_addr[AW+1:2]];
        end
    end

    // Credit counts pipeline + FIFO occupancy; a pop only frees credit once
    // the counter has updated, i.e. the following cycle.
    assign req_ready = !reset && !flush && (outstanding_q < CW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // ------------------------------------------------------------------
    // Lookup pipeline: LATENCY-1 register stages, the FIFO is the last one
    // ------------------------------------------------------------------
    logic       tail_valid;
    rsp_entry_t tail_data;

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign tail_valid = accept;
            assign tail_data  = lookup;
        end else begin : g_pipe
            localparam int unsigned NS = LATENCY - 1;

            logic [NS-1:0] pipe_valid_q, pipe_valid_d;
            rsp_entry_t    pipe_data_q [NS];
            rsp_entry_t    pipe_data_d [NS];

            // Advance every stage each cycle; flush kills all in-flight valids.
            always_comb begin
                pipe_valid_d[0] = accept;
                pipe_data_d[0]  = lookup;
                for (int i = 1; i < NS; i++) begin
                    pipe_valid_d[i] = pipe_valid_q[i-1];
                    pipe_data_d[i]  = pipe_data_q[i-1];
                end
                if (flush) begin
                    pipe_valid_d = '0;
                end
            end

            // Stage registers; payload needs no reset.
            always_ff @(posedge clk) begin
                // NOTE: only the valid bits are reset; a payload is ignored
                // whenever its valid is low, so resetting it buys nothing.
                if (reset) begin
                    pipe_valid_q <= '0;
                end else begin
                    pipe_valid_q <= pipe_valid_d;
                end
                pipe_data_q <= pipe_data_d;
            end

            assign tail_valid = pipe_valid_q[NS-1];
            assign tail_data  = pipe_data_q[NS-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // In-order response FIFO
    // ------------------------------------------------------------------
    rsp_entry_t    fifo_q [FIFO_DEPTH];
    rsp_entry_t    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;

    // Pointer increment with wrap at a depth that need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // FIFO and credit next state. Credit guarantees a push never finds the
    // FIFO full. Flush empties everything; a same-cycle pop has already been
    // consumed by the fetch stage, so dropping it here is correct.
    always_comb begin
        push          = tail_valid && !flush;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            outstanding_d = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = tail_data;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d       = count_q + CW'(push) - CW'(pop);
            outstanding_d = outstanding_q + CW'(accept) - CW'(pop);
        end
    end

    // FIFO state; storage is cleared too because its head drives rsp_instr
    // and rsp_err, which must read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Head of the FIFO; holds still while the fetch stage stalls.
    assign rsp_valid = (count_q != '0);
    assign rsp_instr = fifo_q[rd_ptr_q].instr;
    assign rsp_err   = fifo_q[rd_ptr_q].err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder (DEPTH_WORDS=256, LATENCY=2).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge that updates the design.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush;
    logic        ld_en;
    logic [63:0] ld_addr;
    logic [31:0] ld_data;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0050_0093;
    localparam logic [31:0] W1  = 32'h00A0_0113;
    localparam logic [31:0] W2  = 32'h1111_1111;
    localparam logic [31:0] W3  = 32'h3333_3333;
    localparam logic [31:0] W255 = 32'h1234_5678;

    instr_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
    endtask

    // Start a new cycle: wait for the falling edge and return inputs to idle.
    task automatic begin_cycle();
        @(negedge clk);
        drive_idle();
    endtask

    task automatic load_word(input logic [63:0] a, input logic [31:0] d);
        begin_cycle();
        ld_en = 1'b1; ld_addr = a; ld_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        begin_cycle();
        begin_cycle();
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_instr !== 32'h0) begin n_err++; $display("FAIL rst_rsp_instr: got %h want 00000000", rsp_instr); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready_in_reset: got %b want 0", req_ready); end
        begin_cycle();
        reset = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready_after: got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid_after: got %b want 0", rsp_valid); end
    endtask

    task automatic preload_store();
        load_word(64'h0,   W0);
        load_word(64'h4,   W1);
        load_word(64'h8,   W2);
        load_word(64'hC,   W3);
        load_word(64'h3FC, W255);
    endtask

    // Two consecutive fetches; responses at t+2 and t+3.
    task automatic test_fetch();
        begin_cycle(); req_valid = 1'b1; req_addr = 64'h0; #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fetch_ready_t0: got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fetch_valid_t0: got %b want 0", rsp_valid); end
        begin_cycle(); req_valid = 1'b1; req_addr = 64'h4; #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fetch_ready_t1: got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fetch_valid_t1: got %b want 0", rsp_valid); end
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid_t2: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_instr !== W0) begin n_err++; $display("FAIL fetch_instr_t2: got %h want %h", rsp_instr, W0); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL fetch_err_t2: got %b want 0", rsp_err); end
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid_t3: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_instr !== W1) begin n_err++; $display("FAIL fetch_instr_t3: got %h want %h", rsp_instr, W1); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL fetch_err_t3: got %b want 0", rsp_err); end
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fetch_valid_t4: got %b want 0", rsp_valid); end
    endtask

    // Misaligned, out-of-range, last word and upper-address-bit cases,
    // issued back to back at full throughput.
    task automatic test_errors();
        logic [63:0] addr [4];
        logic [31:0] ex_i [4];
        logic        ex_e [4];
        addr = '{64'h6, 64'h400, 64'h3FC, 64'h1_0000_0000};
        ex_i = '{NOP, NOP, W255, NOP};
        ex_e = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 7; c++) begin
            begin_cycle();
            if (c < 4) begin req_valid = 1'b1; req_addr = addr[c]; end
            #1;
            if (c < 4) begin
                n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL err_ready[%0d]: got %b want 1", c, req_ready); end
            end
            if (c >= 2 && c < 6) begin
                n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL err_valid[%0d]: got %b want 1", c - 2, rsp_valid); end
                n_vec++; if (rsp_instr !== ex_i[c-2]) begin n_err++; $display("FAIL err_instr[%0d]: got %h want %h", c - 2, rsp_instr, ex_i[c-2]); end
                n_vec++; if (rsp_err !== ex_e[c-2]) begin n_err++; $display("FAIL err_flag[%0d]: got %b want %b", c - 2, rsp_err, ex_e[c-2]); end
            end else begin
                n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL err_idle_valid[c%0d]: got %b want 0", c, rsp_valid); end
            end
        end
    endtask

    // Stalled consumer: exactly three accepted, head held stable, then drain
    // in order and the fourth request goes in the cycle after the first pop.
    task automatic test_backpressure();
        int          acc;
        logic [31:0] ex_i [5];
        logic        ex_v [5];
        logic        ex_r [2];
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            begin_cycle();
            rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'(acc) << 2;
            #1;
            n_vec++; if (req_ready !== (c < 3)) begin n_err++; $display("FAIL bp_ready[c%0d]: got %b want %b", c, req_ready, (c < 3)); end
            if (req_ready === 1'b1) acc++;
            if (c >= 2) begin
                n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[c%0d]: got %b want 1", c, rsp_valid); end
                n_vec++; if (rsp_instr !== W0) begin n_err++; $display("FAIL bp_hold_instr[c%0d]: got %h want %h", c, rsp_instr, W0); end
            end else begin
                n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_early_valid[c%0d]: got %b want 0", c, rsp_valid); end
            end
        end
        n_vec++; if (acc != 3) begin n_err++; $display("FAIL bp_accept_count: got %0d want 3", acc); end
        ex_i = '{W0, W1, W2, W3, 32'h0};
        ex_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ex_r = '{1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            begin_cycle();
            req_valid = (k < 2); req_addr = 64'(acc) << 2;
            #1;
            if (k < 2) begin
                n_vec++; if (req_ready !== ex_r[k]) begin n_err++; $display("FAIL bp_drain_ready[%0d]: got %b want %b", k, req_ready, ex_r[k]); end
            end
            if (req_valid && req_ready) acc++;
            n_vec++; if (rsp_valid !== ex_v[k]) begin n_err++; $display("FAIL bp_drain_valid[%0d]: got %b want %b", k, rsp_valid, ex_v[k]); end
            if (ex_v[k]) begin
                n_vec++; if (rsp_instr !== ex_i[k]) begin n_err++; $display("FAIL bp_drain_instr[%0d]: got %h want %h", k, rsp_instr, ex_i[k]); end
            end
        end
        n_vec++; if (acc != 4) begin n_err++; $display("FAIL bp_final_count: got %0d want 4", acc); end
    endtask

    // Flush with one response buffered (popped in the flush cycle) and one
    // in flight; only the post-flush request may ever respond.
    task automatic test_flush();
        begin_cycle(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h0; #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_c0: got %b want 1", req_ready); end
        begin_cycle(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h8; #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_c1: got %b want 1", req_ready); end
        begin_cycle(); flush = 1'b1; req_valid = 1'b1; req_addr = 64'hC; #1;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_flush: got %b want 0", req_ready); end
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL fl_valid_flush: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_instr !== W0) begin n_err++; $display("FAIL fl_instr_flush: got %h want %h", rsp_instr, W0); end
        begin_cycle(); req_valid = 1'b1; req_addr = 64'h4; #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_after: got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid_after: got %b want 0", rsp_valid); end
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid_stale: got %b want 0", rsp_valid); end
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL fl_new_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_instr !== W1) begin n_err++; $display("FAIL fl_new_instr: got %h want %h", rsp_instr, W1); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL fl_new_err: got %b want 0", rsp_err); end
        for (int c = 0; c < 3; c++) begin
            begin_cycle(); #1;
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fl_tail_valid[%0d]: got %b want 0", c, rsp_valid); end
        end
    endtask

    // Reset with three outstanding: nothing old survives, the store does.
    task automatic test_reset_midstream();
        for (int c = 0; c < 3; c++) begin
            begin_cycle(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'(c) << 2; #1;
            n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready[c%0d]: got %b want 1", c, req_ready); end
        end
        begin_cycle(); reset = 1'b1; rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'hC; #1;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready_in_reset: got %b want 0", req_ready); end
        begin_cycle(); reset = 1'b0; #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_instr !== 32'h0) begin n_err++; $display("FAIL rm_rsp_instr: got %h want 00000000", rsp_instr); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rm_rsp_err: got %b want 0", rsp_err); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_after: got %b want 1", req_ready); end
        for (int c = 0; c < 4; c++) begin
            begin_cycle(); #1;
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_ghost_valid[%0d]: got %b want 0", c, rsp_valid); end
        end
        begin_cycle(); req_valid = 1'b1; req_addr = 64'h4; #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rm_refetch_ready: got %b want 1", req_ready); end
        begin_cycle(); #1;
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rm_refetch_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_instr !== W1) begin n_err++; $display("FAIL rm_refetch_instr: got %h want %h", rsp_instr, W1); end
    endtask

    // Load and read of word 2 in the same cycle: old data, then new data.
    task automatic test_load_collision();
        begin_cycle();
        ld_en = 1'b1; ld_addr = 64'h8; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 64'h8;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL col_ready: got %b want 1", req_ready); end
        begin_cycle(); req_valid = 1'b1; req_addr = 64'h8; #1;
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL col_old_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_instr !== W2) begin n_err++; $display("FAIL col_old_instr: got %h want %h", rsp_instr, W2); end
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL col_new_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_instr !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL col_new_instr: got %h want deadbeef", rsp_instr); end
        begin_cycle(); #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL col_tail_valid: got %b want 0", rsp_valid); end
    endtask

    // Misaligned / out-of-range loads are dropped; flush does not block a load.
    task automatic test_load_ignore();
        logic [63:0] addr [3];
        logic [31:0] ex_i [3];
        load_word(64'h5,           32'hBAD0_0001);
        load_word(64'h400,         32'hBAD0_0002);
        load_word(64'h1_0000_0004, 32'hBAD0_0003);
        load_word(64'hC,           32'h4444_4444);
        flush = 1'b1;
        addr = '{64'h0, 64'h4, 64'hC};
        ex_i = '{W0, W1, 32'h4444_4444};
        for (int c = 0; c < 6; c++) begin
            begin_cycle();
            if (c < 3) begin req_valid = 1'b1; req_addr = addr[c]; end
            #1;
            if (c >= 2 && c < 5) begin
                n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL ldi_valid[%0d]: got %b want 1", c - 2, rsp_valid); end
                n_vec++; if (rsp_instr !== ex_i[c-2]) begin n_err++; $display("FAIL ldi_instr[%0d]: got %h want %h", c - 2, rsp_instr, ex_i[c-2]); end
            end
        end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL ldi_tail_valid: got %b want 0", rsp_valid); end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        preload_store();
        test_fetch();
        test_errors();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_load_collision();
        test_load_ignore();
        begin_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
